// File: rtl/a5_pkg.sv
// a5_pkg: shared state encoding and A5/1 geometry constants for the frame sequencer.
package a5_pkg;
  localparam int A5_KEY_W      = 64;
  localparam int A5_FRAME_W    = 22;
  localparam int A5_WORD_W     = 32;
  localparam int A5_FRAME_BITS = 228;
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, FETCH, EMIT, NEXT} state_t;
endpackage

// File: rtl/a5_out_reg.sv
// a5_out_reg: single-entry valid/ready holding register; flush drops an unaccepted word.
module a5_out_reg #(
  parameter int DATA_W  = 32,
  parameter int FRAME_W = 22
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic               i_last,
  input  logic               i_flush,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_data,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_last
);
  logic               r_valid;
  logic [DATA_W-1:0]  r_data;
  logic [FRAME_W-1:0] r_frame;
  logic               r_last;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_frame <= '0;
      r_last  <= 1'b0;
    end else begin
      r_valid <= !i_flush && (i_load || (r_valid && !i_ready));
      if (i_load) begin
        r_data  <= i_data;
        r_frame <= i_frame;
        r_last  <= i_last;
      end
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_frame = r_frame;
  assign o_last  = r_last;
endmodule

// File: rtl/a5_frame_sequencer.sv
// a5_frame_sequencer: drives the A5/1 keystream buffer frame by frame and streams
// its words to a valid/ready consumer.
module a5_frame_sequencer
  import a5_pkg::*;
#(
  parameter int WORDS_PER_FRAME = (A5_FRAME_BITS + A5_WORD_W - 1) / A5_WORD_W,
  parameter int FRAME_W         = A5_FRAME_W,
  parameter int COUNT_W         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [A5_KEY_W-1:0]  cfg_key,
  input  logic [FRAME_W-1:0]   cfg_frame,
  input  logic [COUNT_W-1:0]   cfg_num_frames,
  output logic                 busy,
  output logic                 done,
  output logic                 gen_load,
  output logic [A5_KEY_W-1:0]  gen_key,
  output logic [FRAME_W-1:0]   gen_frame,
  output logic                 gen_rd_en,
  input  logic [A5_WORD_W-1:0] gen_data,
  input  logic                 gen_empty,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A5_WORD_W-1:0] out_data,
  output logic [FRAME_W-1:0]   out_frame,
  output logic                 out_last
);
  localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
  state_t              r_state, w_next;
  logic [A5_KEY_W-1:0] r_key;
  logic [FRAME_W-1:0]  r_frame;
  logic [COUNT_W-1:0]  r_target, r_count, w_count_inc;
  logic [IDX_W-1:0]    r_word_idx;
  logic                r_done;
  logic                w_accept, w_hs, w_last_word, w_finish;
  assign w_accept    = (r_state == IDLE) && start && !stop;
  assign w_hs        = out_valid && out_ready;
  assign w_last_word = r_word_idx == IDX_W'(WORDS_PER_FRAME - 1);
  assign w_count_inc = r_count + 1'b1;
  assign w_finish    = (r_target != '0) && (w_count_inc == r_target);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  // stop overrides every transition, so no load or pop escapes in the abort cycle
  always_comb begin
    w_next    = r_state;
    gen_load  = 1'b0;
    gen_rd_en = 1'b0;
    if (stop) w_next = IDLE;
    else case (r_state)
      IDLE:    w_next = start ? LOAD : IDLE;
      LOAD:    begin
        gen_load = 1'b1;
        w_next   = SETTLE;
      end
      SETTLE:  w_next = FETCH;
      FETCH:   begin
        gen_rd_en = !gen_empty;
        w_next    = gen_empty ? FETCH : EMIT;
      end
      EMIT:    w_next = !w_hs ? EMIT : out_last ? NEXT : FETCH;
      NEXT:    w_next = w_finish ? IDLE : LOAD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key      <= '0;
      r_frame    <= '0;
      r_target   <= '0;
      r_count    <= '0;
      r_word_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= (r_state == NEXT) && !stop && w_finish;
      if (w_accept) begin
        r_key    <= cfg_key;
        r_frame  <= cfg_frame;
        r_target <= cfg_num_frames;
        r_count  <= '0;
      end
      if (gen_load) r_word_idx <= '0;
      if ((r_state == EMIT) && w_hs && !stop && !out_last) r_word_idx <= r_word_idx + 1'b1;
      if ((r_state == NEXT) && !stop) begin
        r_frame <= r_frame + 1'b1;
        r_count <= w_count_inc;
      end
    end
  end
  assign busy      = r_state != IDLE;
  assign done      = r_done;
  assign gen_key   = r_key;
  assign gen_frame = r_frame;
  a5_out_reg #(.DATA_W(A5_WORD_W), .FRAME_W(FRAME_W)) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (gen_rd_en),
    .i_data  (gen_data),
    .i_frame (r_frame),
    .i_last  (w_last_word),
    .i_flush (stop),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_frame (out_frame),
    .o_last  (out_last)
  );
endmodule

// File: tb/tb_a5_frame_sequencer.sv
// tb_a5_frame_sequencer: directed bench with a behavioural keystream buffer and word scoreboard.
module tb_a5_frame_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, out_ready = 1'b1;
  logic [63:0] cfg_key = '0;
  logic [21:0] cfg_frame = '0;
  logic [15:0] cfg_num_frames = '0;
  logic        busy, done, gen_load, gen_rd_en, gen_empty, out_valid, out_last;
  logic [63:0] gen_key;
  logic [21:0] gen_frame, out_frame;
  logic [31:0] gen_data, out_data;
  always #5 clk = ~clk;
  a5_frame_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_key(cfg_key), .cfg_frame(cfg_frame), .cfg_num_frames(cfg_num_frames),
    .busy(busy), .done(done), .gen_load(gen_load), .gen_key(gen_key), .gen_frame(gen_frame),
    .gen_rd_en(gen_rd_en), .gen_data(gen_data), .gen_empty(gen_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_frame(out_frame), .out_last(out_last)
  );
  // buffer model: word = {2'b01, index in frame, frame}; empty for stall_len cycles after each load
  logic [21:0] b_frame = '0;
  logic [7:0]  b_idx = '0;
  int          stall = 0, stall_len = 0;
  logic        force_empty = 1'b0;
  assign gen_empty = force_empty || (stall != 0);
  assign gen_data  = {2'b01, b_idx, b_frame};
  always @(posedge clk) begin
    if (gen_load) begin
      b_frame <= gen_frame;
      b_idx   <= '0;
      stall   <= stall_len;
    end else begin
      if (gen_rd_en) b_idx <= b_idx + 8'd1;
      if (stall != 0) stall <= stall - 1;
    end
  end
  int n_checks = 0, n_errors = 0;
  int n_loads, n_words, n_lasts, n_done, n_pops, exp_idx, cyc = 0, ready_mode = 0;
  logic [63:0] load_key[$];
  logic [21:0] load_frm[$];
  logic [21:0] exp_frame, prev_frm;
  logic [31:0] prev_data;
  logic        prev_stall = 1'b0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (cyc % 3 == 0) : (n_words < 11);
  end
  always @(negedge clk) if (!reset) begin
    if (gen_load) begin
      n_loads++;
      load_key.push_back(gen_key);
      load_frm.push_back(gen_frame);
    end
    if (gen_rd_en) begin
      n_pops++;
      check("rd_when_empty", gen_empty, 0);
    end
    if (done) n_done++;
    if (prev_stall && out_valid) begin
      check("hold_data", out_data, prev_data);
      check("hold_frame", out_frame, prev_frm);
    end
    if (out_valid && out_ready) begin
      check("word_data", out_data, {2'b01, 8'(exp_idx), exp_frame});
      check("word_frame", out_frame, exp_frame);
      check("word_last", out_last, exp_idx == 7);
      n_words++;
      if (out_last) n_lasts++;
      exp_idx++;
      if (exp_idx == 8) begin
        exp_idx = 0;
        exp_frame++;
      end
    end
    prev_stall = out_valid && !out_ready && !stop;
    prev_data  = out_data;
    prev_frm   = out_frame;
  end
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic clr();
    n_loads = 0; n_words = 0; n_lasts = 0; n_done = 0; n_pops = 0;
    load_key.delete();
    load_frm.delete();
    prev_stall = 1'b0;
  endtask
  task automatic go(input logic [63:0] k, input logic [21:0] f, input logic [15:0] n);
    cfg_key = k; cfg_frame = f; cfg_num_frames = n;
    exp_frame = f; exp_idx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_seen", i < budget, 1);
    check("busy_at_done", busy, 0);
    tick();
  endtask
  task automatic idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_load"}, gen_load, 0);
    check({tag, "_key"}, gen_key, 0);
    check({tag, "_frame"}, gen_frame, 0);
    check({tag, "_rd_en"}, gen_rd_en, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_last"}, out_last, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tick(2);
    idle_outputs("reset");
    reset = 1'b0;
    tick();
    // single frame
    clr();
    cfg_key = 64'h0123456789ABCDEF; cfg_frame = 22'h000134; cfg_num_frames = 16'd1;
    exp_frame = 22'h000134; exp_idx = 0;
    start = 1'b1;
    @(negedge clk);
    check("busy_pre", busy, 0);
    tick();
    start = 1'b0;
    check("busy_rise", busy, 1);
    check("load_pulse", gen_load, 1);
    wait_done(200);
    check("t1_loads", n_loads, 1);
    check("t1_key", load_key[0], 64'h0123456789ABCDEF);
    check("t1_frame", load_frm[0], 22'h000134);
    check("t1_words", n_words, 8);
    check("t1_lasts", n_lasts, 1);
    tick(3);
    check("t1_done_cnt", n_done, 1);
    check("t1_busy", busy, 0);
    // multi-frame with wrap
    clr();
    go(64'hA5A5_0000_FFFF_1234, 22'h3FFFFE, 16'd3);
    wait_done(400);
    check("t2_loads", n_loads, 3);
    check("t2_frame0", load_frm[0], 22'h3FFFFE);
    check("t2_frame1", load_frm[1], 22'h3FFFFF);
    check("t2_frame2", load_frm[2], 22'h000000);
    check("t2_words", n_words, 24);
    check("t2_lasts", n_lasts, 3);
    tick(3);
    check("t2_done_cnt", n_done, 1);
    // backpressure and empty stalls
    clr();
    stall_len = 5;
    ready_mode = 1;
    go(64'h0F0F_F0F0_1357_9BDF, 22'h000055, 16'd2);
    wait_done(600);
    check("t3_pops", n_pops, 16);
    check("t3_words", n_words, 16);
    check("t3_loads", n_loads, 2);
    check("t3_lasts", n_lasts, 2);
    tick(3);
    check("t3_done_cnt", n_done, 1);
    stall_len = 0;
    ready_mode = 0;
    tick();
    // abort in frame 2, word 4, with the consumer stalled
    clr();
    ready_mode = 2;
    go(64'h1234_5678_9ABC_DEF0, 22'h000010, 16'd0);
    begin
      int i;
      for (i = 0; i < 400; i++) begin
        @(negedge clk);
        if (out_valid && !out_ready && n_words == 11) break;
      end
      check("t4_reach", i < 400, 1);
    end
    check("t4_word", out_data, {2'b01, 8'd3, 22'h000011});
    check("t4_wframe", out_frame, 22'h000011);
    tick();
    stop = 1'b1;
    @(negedge clk);
    check("t4_stop_load", gen_load, 0);
    check("t4_stop_rd", gen_rd_en, 0);
    tick();
    stop = 1'b0;
    check("t4_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    tick(3);
    check("t4_no_done", n_done, 0);
    check("t4_valid_idle", out_valid, 0);
    ready_mode = 0;
    tick();
    clr();
    go(64'hFEDCBA9876543210, 22'h000200, 16'd1);
    wait_done(200);
    check("t4_new_key", load_key[0], 64'hFEDCBA9876543210);
    check("t4_new_frame", load_frm[0], 22'h000200);
    check("t4_new_words", n_words, 8);
    // start while busy is ignored
    tick(2);
    clr();
    go(64'h1111_2222_3333_4444, 22'h000020, 16'd1);
    tick(4);
    cfg_key = 64'h5555_6666_7777_8888; cfg_frame = 22'h000300; cfg_num_frames = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    check("t5_loads", n_loads, 1);
    check("t5_key", load_key[0], 64'h1111_2222_3333_4444);
    check("t5_frame", load_frm[0], 22'h000020);
    check("t5_words", n_words, 8);
    tick(3);
    check("t5_done_cnt", n_done, 1);
    // simultaneous start and stop in IDLE
    clr();
    cfg_key = 64'h9999_AAAA_BBBB_CCCC; cfg_frame = 22'h000077; cfg_num_frames = 16'd1;
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_load", gen_load, 0);
    tick(3);
    check("t6_loads", n_loads, 0);
    check("t6_busy_late", busy, 0);
    // asynchronous reset while waiting in FETCH
    clr();
    force_empty = 1'b1;
    go(64'hDEAD_BEEF_CAFE_F00D, 22'h000044, 16'd1);
    tick(6);
    check("t7_busy", busy, 1);
    check("t7_rd", gen_rd_en, 0);
    #2;
    reset = 1'b1;
    #1;
    idle_outputs("t7_async");
    tick(2);
    reset = 1'b0;
    force_empty = 1'b0;
    tick(3);
    check("t7_no_done", n_done, 0);
    check("t7_busy_after", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
